// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step encodings,
// ALU select codes, IR field positions and the decoded strobe bundle.
package ctrl_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;
   localparam int C_HI   = 18;
   localparam int C_LO   = 0;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;

   typedef enum logic [3:0] {
      T0   = 4'd0,
      T1   = 4'd1,
      T2   = 4'd2,
      T3   = 4'd3,
      T4   = 4'd4,
      T5   = 4'd5,
      T6   = 4'd6,
      T7   = 4'd7,
      HALT = 4'd8
   } step_t;

   typedef enum logic [3:0] {
      CLS_LD   = 4'd0,
      CLS_LDI  = 4'd1,
      CLS_ST   = 4'd2,
      CLS_RR   = 4'd3,
      CLS_IMM  = 4'd4,
      CLS_BR   = 4'd5,
      CLS_JR   = 4'd6,
      CLS_HALT = 4'd7,
      CLS_NOP  = 4'd8
   } op_class_t;

   typedef struct packed {
      logic       pc_out;
      logic       zlow_out;
      logic       zhigh_out;
      logic       mdr_out;
      logic       r_out;
      logic       ba_out;
      logic       c_out;
      logic       mar_in;
      logic       z_in;
      logic       pc_in;
      logic       mdr_in;
      logic       ir_in;
      logic       y_in;
      logic       r_in;
      logic       con_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       inc_pc;
      logic       read;
      logic       write;
      logic [3:0] alu_op;
   } ctrl_t;

   // Unknown opcodes fall into the nop class.
   function automatic op_class_t classify(input logic [4:0] opc);
      case (opc)
         OP_LD:                    return CLS_LD;
         OP_LDI:                   return CLS_LDI;
         OP_ST:                    return CLS_ST;
         OP_ADD, OP_SUB,
         OP_AND, OP_OR:            return CLS_RR;
         OP_ADDI, OP_ANDI, OP_ORI: return CLS_IMM;
         OP_BR:                    return CLS_BR;
         OP_JR:                    return CLS_JR;
         OP_HALT:                  return CLS_HALT;
         default:                  return CLS_NOP;
      endcase
   endfunction

   function automatic logic [3:0] alu_sel(input logic [4:0] opc);
      case (opc)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational map from (step, opcode, CON_FF) to the Datapath strobe bundle.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  step_t      step,
   input  logic [4:0] opcode,
   input  logic       con_ff,
   output ctrl_t      ctrl
);

   op_class_t cls;

   assign cls = classify(opcode);

   // Strobe decode per micro-step
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (step)
         T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
            ctrl.z_in   = 1'b1;
         end
         T1: begin
            ctrl.zlow_out = 1'b1;
            ctrl.pc_in    = 1'b1;
            ctrl.read     = 1'b1;
            ctrl.mdr_in   = 1'b1;
         end
         T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         T3: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST: begin
                  ctrl.grb    = 1'b1;
                  ctrl.ba_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               CLS_RR, CLS_IMM: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               CLS_BR: begin
                  ctrl.gra    = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.con_in = 1'b1;
               end
               CLS_JR: begin
                  ctrl.gra   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.pc_in = 1'b1;
               end
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         T4: begin
            case (cls)
               CLS_LD, CLS_LDI, CLS_ST: begin
                  ctrl.c_out = 1'b1;
                  ctrl.z_in  = 1'b1;
               end
               CLS_RR: begin
                  ctrl.grc    = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.z_in   = 1'b1;
                  ctrl.alu_op = alu_sel(opcode);
               end
               CLS_IMM: begin
                  ctrl.c_out  = 1'b1;
                  ctrl.z_in   = 1'b1;
                  ctrl.alu_op = alu_sel(opcode);
               end
               CLS_BR: begin
                  ctrl.pc_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         T5: begin
            case (cls)
               CLS_LD, CLS_ST: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.mar_in   = 1'b1;
               end
               CLS_LDI, CLS_RR, CLS_IMM: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.gra      = 1'b1;
                  ctrl.r_in     = 1'b1;
               end
               CLS_BR: begin
                  ctrl.c_out = 1'b1;
                  ctrl.z_in  = 1'b1;
               end
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         T6: begin
            case (cls)
               CLS_LD: begin
                  ctrl.read   = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               CLS_ST: begin
                  ctrl.gra    = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               CLS_BR: begin
                  if (con_ff) begin
                     ctrl.zlow_out = 1'b1;
                     ctrl.pc_in    = 1'b1;
                  end else begin
                     ctrl.pc_in = 1'b0;
                  end
               end
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         T7: begin
            case (cls)
               CLS_LD: begin
                  ctrl.mdr_out = 1'b1;
                  ctrl.gra     = 1'b1;
                  ctrl.r_in    = 1'b1;
               end
               CLS_ST:  ctrl.write = 1'b1;
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         default: ctrl.alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-specific execute T3-T7, then back to T0.
// Optional CTRL_MEM_WAIT_EN adds Mem_ready, stretching Read/Write steps until memory is ready.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int IR_W     = 32,
   parameter int OPCODE_W = 5,
   parameter int ALU_OP_W = 4
)(
   input  logic                Clock,
   input  logic                Reset,
   input  logic [IR_W-1:0]     IR,
   input  logic                CON_FF,
`ifdef CTRL_MEM_WAIT_EN
   input  logic                Mem_ready,
`endif
   output logic                PCout,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                MDRout,
   output logic                Rout,
   output logic                BAout,
   output logic                Cout,
   output logic                MARin,
   output logic                Zin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                Rin,
   output logic                CONin,
   output logic                Gra,
   output logic                Grb,
   output logic                Grc,
   output logic                IncPC,
   output logic                Read,
   output logic                Write,
   output logic [ALU_OP_W-1:0] ALU_op,
   output logic                Run
);

   step_t             step_r;
   step_t             step_next;
   logic [OPCODE_W-1:0] opcode;
   op_class_t         cls;
   ctrl_t             dec;
   ctrl_t             ctrl;
   logic              hold;
   logic              ir_unused;

   assign opcode    = IR[OPC_HI:OPC_LO];
   assign ir_unused = ^IR[OPC_LO-1:0];
   assign cls       = classify(opcode);

   ctrl_decode u_decode (
      .step   (step_r),
      .opcode (opcode),
      .con_ff (CON_FF),
      .ctrl   (dec)
   );

   // A memory step stalls in place until Mem_ready is seen at an edge.
   always_comb begin
      hold = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
      hold = (dec.read | dec.write) & ~Mem_ready;
`endif
   end

   // Next-step selection
   always_comb begin
      step_next = T0;
      case (step_r)
         T0: step_next = T1;
         T1: step_next = T2;
         T2: step_next = T3;
         T3: begin
            case (cls)
               CLS_JR, CLS_NOP: step_next = T0;
               CLS_HALT:        step_next = HALT;
               default:         step_next = T4;
            endcase
         end
         T4: step_next = T5;
         T5: begin
            case (cls)
               CLS_LD, CLS_ST, CLS_BR: step_next = T6;
               default:                step_next = T0;
            endcase
         end
         T6: begin
            if (cls == CLS_LD || cls == CLS_ST) begin
               step_next = T7;
            end else begin
               step_next = T0;
            end
         end
         T7:      step_next = T0;
         HALT:    step_next = HALT;
         default: step_next = T0;
      endcase
      if (hold) begin
         step_next = step_r;
      end else begin
         step_next = step_next;
      end
   end

   // Step register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         step_r <= T0;
      end else begin
         step_r <= step_next;
      end
   end

   // Reset forces every strobe low even though the step already sits at T0.
   assign ctrl     = Reset ? '0 : dec;
   assign Run      = ~Reset & (step_r <= T7);
   assign PCout    = ctrl.pc_out;
   assign Zlowout  = ctrl.zlow_out;
   assign Zhighout = ctrl.zhigh_out;
   assign MDRout   = ctrl.mdr_out;
   assign Rout     = ctrl.r_out;
   assign BAout    = ctrl.ba_out;
   assign Cout     = ctrl.c_out;
   assign MARin    = ctrl.mar_in;
   assign Zin      = ctrl.z_in;
   assign PCin     = ctrl.pc_in;
   assign MDRin    = ctrl.mdr_in;
   assign IRin     = ctrl.ir_in;
   assign Yin      = ctrl.y_in;
   assign Rin      = ctrl.r_in;
   assign CONin    = ctrl.con_in;
   assign Gra      = ctrl.gra;
   assign Grb      = ctrl.grb;
   assign Grc      = ctrl.grc;
   assign IncPC    = ctrl.inc_pc;
   assign Read     = ctrl.read;
   assign Write    = ctrl.write;
   assign ALU_op   = ALU_OP_W'(ctrl.alu_op);

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath's bus-transfer and register-enable strobes, one micro-step per Clock.
- It replaces bench-driven T0..T7 stimulus. It runs instruction fetch (T0-T2), then an opcode-specific execute sequence (T3-T7), then returns to T0.
- It sits beside Datapath. Its inputs are the IR contents and the CON flip-flop. Its outputs are all Datapath control inputs plus an ALU operation select.

Parameters:
- IR_W, 32, instruction register width.
- OPCODE_W, 5, opcode field width, taken from IR[31:27].
- ALU_OP_W, 4, width of ALU_op.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IR  in  IR_W  current instruction register contents from Datapath.
- CON_FF  in  1  branch condition flip-flop from Datapath.
- PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin  out  1 each  register load enables.
- Gra, Grb, Grc  out  1 each  register-field selects.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- ALU_op  out  ALU_OP_W  operation select: 0=ADD, 1=SUB, 2=AND, 3=OR.
- Run  out  1  high while executing; low in HALT and during Reset.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- While Reset=1: step=T0, every output 0, Run=0. The first cycle after Reset deasserts is T0. Reset mid-instruction abandons that instruction.
- Outputs are a combinational decode of the registered step and the opcode. Each asserted strobe holds for the whole step cycle. Unlisted outputs are 0. ALU_op defaults to ADD.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, andi=01101, ori=01110, br=10010, jr=10100, nop=11010, halt=11011. Any other opcode executes as nop.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin; then T0.
- ldi: T3-T4 as ld; T5: Zlowout, Gra, Rin; then T0.
- st:
  - T3-T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write; then T0.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU_op per opcode.
  - T5: Zlowout, Gra, Rin; then T0.
- addi/andi/ori:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, ALU_op ADD/AND/OR.
  - T5: as R-type; then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin.
  - T6: if CON_FF=1, Zlowout and PCin; else no strobes. Then T0.
  - CON_FF is sampled in T6 only.
- jr: T3: Gra, Rout, PCin; then T0.
- nop: T3 with no strobes; then T0.
- halt: T3 then HALT. HALT has no strobes, Run=0, and is left only by Reset.
- Step register is 4 bits: T0..T7 plus HALT. No state other than T0..T7/HALT is reachable; an illegal encoding recovers to T0.

Optional Feature:
- Macro: CTRL_MEM_WAIT_EN.
- Enabled:
  - Adds input Mem_ready (1 bit).
  - Steps carrying Read or Write (fetch T1, ld T6, st T7) hold, with strobes held asserted, until Mem_ready=1 is sampled at a rising edge. They then advance.
  - Reset during a wait aborts normally.
- Disabled: no Mem_ready port; every step lasts exactly one cycle.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - step encodings T0..T7 and HALT;
  - ALU_op codes ADD/SUB/AND/OR;
  - IR field positions: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0].
- One natural sub-module: ctrl_decode, a purely combinational (step, opcode, CON_FF) -> strobe vector.
- The top keeps the step register and the wait logic.

Test Plan:
- Reset high 3 cycles, release, IR=0x00800055 (ld r1,0x55(r0)) after T2 -> all outputs 0 during Reset; exact T0..T7 strobes as listed; T7 MDRout=Gra=Rin=1; 8 cycles, back to T0.
- IR=0x18918000 (add r1,r2,r3) -> T4 Grc=Rout=Zin=1, ALU_op=0; T5 Rin=1; 6-cycle instruction.
- IR=0x20918000 (sub) then IR=0x68900007 (andi) -> T4 ALU_op=1, then T4 ALU_op=2 with Cout=1.
- IR=0x90080003 (br) with CON_FF=0, repeated with CON_FF=1 -> T6 PCin=0 in the first run; T6 Zlowout=PCin=1 in the second.
- IR=0xD8000000 (halt) -> Run falls after T3 and all strobes stay 0 for 20 cycles. Async Reset mid-ld (during T5) -> outputs 0 immediately; restart at T0.
- CTRL_MEM_WAIT_EN build, Mem_ready=0 for 3 cycles in T1 -> Read=MDRin=Zlowout=PCin held 4 cycles; T2 follows the cycle Mem_ready=1.
